// File: rtl/elbeth_alu_sequencer.sv
// Sequencer that issues one operation at a time to an external elbeth_alu.
// It registers the operands and captures the result into a ready/valid response.
module elbeth_alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int NUM_OPS    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [OP_WIDTH-1:0]   req_op,
  output logic [DATA_WIDTH-1:0] alu_data_a,
  output logic [DATA_WIDTH-1:0] alu_data_b,
  output logic [OP_WIDTH-1:0]   alu_operation,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_zero,
  output logic                  resp_error,
  output logic [31:0]           op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   op_legal;

  assign op_legal   = (32'(req_op) < NUM_OPS);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Illegal opcodes skip EXEC and answer immediately with an error response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      alu_data_a    <= '0;
      alu_data_b    <= '0;
      alu_operation <= '0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_error    <= 1'b0;
      op_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_data_a    <= req_a;
            alu_data_b    <= req_b;
            alu_operation <= req_op;
            if (op_legal) begin
              state <= EXEC;
            end else begin
              resp_result <= '0;
              resp_zero   <= 1'b0;
              resp_error  <= 1'b1;
              state       <= RESP;
            end
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= (alu_result == '0);
          resp_error  <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            op_count <= op_count + 32'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_alu_sequencer.sv
// Self-checking bench for elbeth_alu_sequencer: drives requests against a
// bench-side ALU and compares responses with a transaction-level model.
module tb_elbeth_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic [31:0] alu_data_a;
  logic [31:0] alu_data_b;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_error;
  logic [31:0] op_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_count = '0;

  elbeth_alu_sequencer #(.DATA_WIDTH(32), .OP_WIDTH(4), .NUM_OPS(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_data_a(alu_data_a), .alu_data_b(alu_data_b), .alu_operation(alu_operation),
    .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_error(resp_error),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Bench-side stand-in for elbeth_alu; illegal opcodes return junk on purpose.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return 32'($signed(a) >>> b[4:0]);
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return a;
      4'd11:   return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_model(alu_data_a, alu_data_b, alu_operation);

  // Present one request and count edges until a response appears (bounded).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output int lat);
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
    tests_run++; if ({resp_result, resp_zero, resp_error} !== 34'd0) begin tests_failed++; $display("[TB] FAIL reset_resp got %h/%b/%b want 0", resp_result, resp_zero, resp_error); end
    tests_run++; if ({alu_data_a, alu_data_b, alu_operation} !== 68'd0) begin tests_failed++; $display("[TB] FAIL reset_alu got %h/%h/%h want 0", alu_data_a, alu_data_b, alu_operation); end
    tests_run++; if (op_count !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_op_count got %0d want 0", op_count); end
    rst = 1'b0;
    model_count = '0;
  endtask

  task automatic test_directed();
    int lat;
    logic [31:0] a [3] = '{32'd3, 32'd5, 32'b1010};
    logic [31:0] b [3] = '{32'd4, 32'd5, 32'b0101};
    logic [3:0]  op[3] = '{4'd0, 4'd1, 4'd3};
    logic [31:0] res[3] = '{32'd7, 32'd0, 32'b1111};
    for (int i = 0; i < 3; i++) begin
      issue(a[i], b[i], op[i], lat);
      tests_run++; if (lat !== 2) begin tests_failed++; $display("[TB] FAIL directed%0d_latency got %0d want 2", i, lat); end
      tests_run++; if (resp_result !== res[i]) begin tests_failed++; $display("[TB] FAIL directed%0d_result got %h want %h", i, resp_result, res[i]); end
      tests_run++; if (resp_zero !== (res[i] == 0)) begin tests_failed++; $display("[TB] FAIL directed%0d_zero got %b want %b", i, resp_zero, res[i] == 0); end
      tests_run++; if (resp_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL directed%0d_error got %b want 0", i, resp_error); end
      handshake();
      model_count++;
      tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL directed%0d_count got %0d want %0d", i, op_count, model_count); end
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [3:0] ops[2] = '{4'd15, 4'd12};
    for (int i = 0; i < 2; i++) begin
      issue(32'h1234_5678, 32'h9, ops[i], lat);
      tests_run++; if (lat !== 1) begin tests_failed++; $display("[TB] FAIL illegal%0d_latency got %0d want 1", i, lat); end
      tests_run++; if ({resp_error, resp_zero, resp_result} !== {1'b1, 1'b0, 32'd0}) begin tests_failed++; $display("[TB] FAIL illegal%0d_resp got err=%b zero=%b res=%h want 1/0/0", i, resp_error, resp_zero, resp_result); end
      tests_run++; if ({alu_data_a, alu_operation} !== {32'h1234_5678, ops[i]}) begin tests_failed++; $display("[TB] FAIL illegal%0d_alu got %h/%h want 12345678/%h", i, alu_data_a, alu_operation, ops[i]); end
      handshake();
      model_count++;
      tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL illegal%0d_count got %0d want %0d", i, op_count, model_count); end
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] exp_res = alu_model(32'd100, 32'd23, 4'd1);
    issue(32'd100, 32'd23, 4'd1, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_a = $urandom; req_b = $urandom; req_op = 4'd0;
      tests_run++; if ({resp_valid, req_ready} !== 2'b10) begin tests_failed++; $display("[TB] FAIL stall%0d_handshake got valid=%b ready=%b want 1/0", c, resp_valid, req_ready); end
      tests_run++; if (resp_result !== exp_res || resp_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall%0d_result got %h err=%b want %h", c, resp_result, resp_error, exp_res); end
      tests_run++; if ({alu_data_a, alu_data_b, alu_operation} !== {32'd100, 32'd23, 4'd1}) begin tests_failed++; $display("[TB] FAIL stall%0d_alu got %h/%h/%h want 64/17/1", c, alu_data_a, alu_data_b, alu_operation); end
    end
    req_a = 32'd40; req_b = 32'd2; req_op = 4'd0;
    handshake();
    model_count++;
    tests_run++; if ({req_ready, resp_valid} !== 2'b10 || alu_data_a !== 32'd100) begin tests_failed++; $display("[TB] FAIL stall_release got ready=%b valid=%b a=%h want 1/0/64", req_ready, resp_valid, alu_data_a); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++; if (alu_data_a !== 32'd40 || resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_next_accept got a=%h valid=%b want 28/0", alu_data_a, resp_valid); end
    @(posedge clk); #1;
    tests_run++; if (resp_valid !== 1'b1 || resp_result !== 32'd42) begin tests_failed++; $display("[TB] FAIL stall_next_result got valid=%b res=%h want 1/2a", resp_valid, resp_result); end
    handshake();
    model_count++;
    tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL stall_count got %0d want %0d", op_count, model_count); end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a, b, exp_res;
    logic [3:0] op;
    logic exp_err;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin b = a; op = 4'd1; end
      exp_err = (op >= 4'd12);
      exp_res = exp_err ? 32'd0 : alu_model(a, b, op);
      issue(a, b, op, lat);
      tests_run++; if (lat !== (exp_err ? 1 : 2)) begin tests_failed++; $display("[TB] FAIL rand%0d_latency op=%0d got %0d want %0d", i, op, lat, exp_err ? 1 : 2); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tests_run++; if ({resp_valid, resp_error, resp_zero, resp_result} !== {1'b1, exp_err, !exp_err && exp_res == 0, exp_res}) begin tests_failed++; $display("[TB] FAIL rand%0d_resp op=%0d got v=%b e=%b z=%b r=%h want e=%b r=%h", i, op, resp_valid, resp_error, resp_zero, resp_result, exp_err, exp_res); end
      tests_run++; if ({alu_data_a, alu_data_b, alu_operation} !== {a, b, op}) begin tests_failed++; $display("[TB] FAIL rand%0d_alu got %h/%h/%h want %h/%h/%h", i, alu_data_a, alu_data_b, alu_operation, a, b, op); end
      handshake();
      model_count++;
      tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL rand%0d_count got %0d want %0d", i, op_count, model_count); end
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    @(negedge clk);
    req_a = 32'd3; req_b = 32'd4; req_op = 4'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++; if ({req_ready, resp_valid, resp_result, resp_zero, resp_error} !== {1'b1, 1'b0, 34'd0}) begin tests_failed++; $display("[TB] FAIL midrst_resp got ready=%b valid=%b res=%h", req_ready, resp_valid, resp_result); end
    tests_run++; if ({alu_data_a, alu_data_b, alu_operation, op_count} !== 100'd0) begin tests_failed++; $display("[TB] FAIL midrst_regs got a=%h b=%h op=%h cnt=%0d want 0", alu_data_a, alu_data_b, alu_operation, op_count); end
    model_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_a = 32'd9; req_b = 32'd1; req_op = 4'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++; if (alu_data_a !== 32'd9 || resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_first_accept got a=%h valid=%b want 9/0", alu_data_a, resp_valid); end
    @(posedge clk); #1;
    tests_run++; if (resp_valid !== 1'b1 || resp_result !== 32'd10) begin tests_failed++; $display("[TB] FAIL midrst_after_result got valid=%b res=%h want 1/a", resp_valid, resp_result); end
    handshake();
    model_count++;
    tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL midrst_count got %0d want %0d", op_count, model_count); end
  endtask

  task automatic test_wrap();
    int lat;
    @(negedge clk);
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    #1;
    model_count = 32'hFFFF_FFFF;
    tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL wrap_preload got %h want ffffffff", op_count); end
    issue(32'd1, 32'd1, 4'd14, lat);
    handshake();
    model_count++;
    tests_run++; if (op_count !== model_count) begin tests_failed++; $display("[TB] FAIL wrap_count got %h want %h", op_count, model_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_stall();
    test_random();
    test_reset_midflight();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
